// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits one word-sized CPU bus transaction into sequential
// byte accesses to one of NUM_TGT byte-wide targets chosen by an external map.
// Optional watchdog on each byte access is built when MEM_SEQ_TIMEOUT_EN is defined.
module mem_byte_sequencer #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned NUM_TGT        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_W-1:0]           i_bus_data,
    input  logic [ADDR_W-1:0]           i_bus_address,
    input  logic                        i_bus_DV,
    input  logic [$clog2(DATA_W/8):0]   i_bhw,
    input  logic                        i_write_notread,
    output logic [DATA_W-1:0]           o_bus_data,
    output logic                        o_bus_DV,
    output logic                        o_bus_err,
    output logic                        o_busy,
    output logic [ADDR_W-1:0]           o_sub_addr,
    output logic [7:0]                  o_sub_wdata,
    output logic                        o_sub_wren,
    output logic [NUM_TGT-1:0]          o_sub_req,
    input  logic [NUM_TGT-1:0]          i_sub_sel,
    input  logic [NUM_TGT*8-1:0]        i_sub_rdata,
    input  logic [NUM_TGT-1:0]          i_sub_done
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(LANES) + 1;
    localparam int unsigned TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    lane_q, lane_d;
    logic                wr_q, wr_d;
    logic [TGT_W-1:0]    tgt_q, tgt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                sel_onehot;
    logic [TGT_W-1:0]    sel_idx;
    logic                done_hit;
    logic [7:0]          rd_byte;
    logic [CNT_W-1:0]    lane_inc;

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [WD_W-1:0]     wd_inc;
    assign wd_inc = wd_q + WD_W'(1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Decode the map select: must be exactly one target, and find its index
    always_comb begin
        sel_idx    = '0;
        sel_onehot = (i_sub_sel != '0) &&
                     ((i_sub_sel & (i_sub_sel - NUM_TGT'(1))) == '0);
        for (int t = 0; t < NUM_TGT; t++) begin
            if (i_sub_sel[t]) begin
                sel_idx = TGT_W'(t);
            end
        end
    end

    // Only the latched target's done and read byte are honoured
    always_comb begin
        done_hit = i_sub_done[tgt_q];
        rd_byte  = i_sub_rdata[{tgt_q, 3'b000} +: 8];
        lane_inc = lane_q + CNT_W'(1);
    end

    // Next-state logic for the transfer sequencer
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        wr_d    = wr_q;
        tgt_d   = tgt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_SEQ_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_bus_DV) begin
                    data_d  = i_bus_data;
                    addr_d  = i_bus_address;
                    cnt_d   = i_bhw;
                    wr_d    = i_write_notread;
                    lane_d  = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (i_bhw == '0) begin
                        state_d = StResp;
                    end else if (i_bhw > CNT_W'(LANES)) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!sel_onehot) begin
                    // Unmapped or ambiguous byte aborts with no request issued
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    tgt_d   = sel_idx;
                    state_d = StWait;
`ifdef MEM_SEQ_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            StWait: begin
                if (done_hit) begin
                    if (!wr_q) begin
                        rdata_d[{lane_q, 3'b000} +: 8] = rd_byte;
                    end
                    lane_d  = lane_inc;
                    state_d = (lane_inc == cnt_q) ? StResp : StIssue;
                end
`ifdef MEM_SEQ_TIMEOUT_EN
                else if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wd_d = wd_inc;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            wr_q    <= 1'b0;
            tgt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            wr_q    <= wr_d;
            tgt_q   <= tgt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_SEQ_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Outputs decode from registered state; forced low while reset is asserted
    always_comb begin
        o_busy      = 1'b0;
        o_bus_DV    = 1'b0;
        o_bus_err   = 1'b0;
        o_bus_data  = '0;
        o_sub_addr  = '0;
        o_sub_wdata = '0;
        o_sub_wren  = 1'b0;
        o_sub_req   = '0;
        if (!i_rst) begin
            o_busy     = (state_q != StIdle);
            o_sub_addr = addr_q + ADDR_W'(lane_q);
            if (state_q == StResp) begin
                o_bus_DV   = 1'b1;
                o_bus_err  = err_q;
                o_bus_data = wr_q ? data_q : rdata_q;
            end
            // lane_q is always below the count in these states, so the slice is in range
            if (state_q == StIssue || state_q == StWait) begin
                o_sub_wdata = data_q[{lane_q, 3'b000} +: 8];
                o_sub_wren  = wr_q;
            end
            if (state_q == StIssue && sel_onehot) begin
                o_sub_req = i_sub_sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed testbench for mem_byte_sequencer: table of transfers plus hand-written
// sequences for spurious done, watchdog / WAIT hold, and mid-transfer reset.
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst;
    logic [31:0] i_bus_data;
    logic [31:0] i_bus_address;
    logic        i_bus_DV;
    logic [2:0]  i_bhw;
    logic        i_write_notread;
    logic [31:0] o_bus_data;
    logic        o_bus_DV;
    logic        o_bus_err;
    logic        o_busy;
    logic [31:0] o_sub_addr;
    logic [7:0]  o_sub_wdata;
    logic        o_sub_wren;
    logic [1:0]  o_sub_req;
    logic [1:0]  i_sub_sel;
    logic [15:0] i_sub_rdata;
    logic [1:0]  i_sub_done;

    mem_byte_sequencer #(
        .DATA_W(32),
        .ADDR_W(32),
        .NUM_TGT(2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_bus_data(i_bus_data),
        .i_bus_address(i_bus_address),
        .i_bus_DV(i_bus_DV),
        .i_bhw(i_bhw),
        .i_write_notread(i_write_notread),
        .o_bus_data(o_bus_data),
        .o_bus_DV(o_bus_DV),
        .o_bus_err(o_bus_err),
        .o_busy(o_busy),
        .o_sub_addr(o_sub_addr),
        .o_sub_wdata(o_sub_wdata),
        .o_sub_wren(o_sub_wren),
        .o_sub_req(o_sub_req),
        .i_sub_sel(i_sub_sel),
        .i_sub_rdata(i_sub_rdata),
        .i_sub_done(i_sub_done)
    );

    // Address map: 0x0xxx -> tgt0, 0x1xxx -> tgt1, 0x3xxx unmapped, else tgt0
    function automatic logic [1:0] map_sel(input logic [31:0] a);
        case (a[15:12])
            4'h1:    return 2'b10;
            4'h3:    return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    // tgt0 returns 0x11*(a[1:0]+1); tgt1 returns {A, a[3:0]}
    function automatic logic [7:0] tgt_byte(input int t, input logic [31:0] a);
        if (t == 0) return 8'(17 * (int'(a[1:0]) + 1));
        return {4'hA, a[3:0]};
    endfunction

    logic       done_en;
    logic [1:0] spur;
    logic [1:0] done_q;
    logic [7:0] rd0_q, rd1_q;

    assign i_sub_sel   = map_sel(o_sub_addr);
    assign i_sub_rdata = {rd1_q, rd0_q};
    assign i_sub_done  = done_q | spur;

    // Single-cycle targets: done and read byte one cycle after the request
    always @(posedge clk) begin
        done_q <= o_sub_req & {2{done_en}};
        if (o_sub_req[0]) rd0_q <= tgt_byte(0, o_sub_addr);
        if (o_sub_req[1]) rd1_q <= tgt_byte(1, o_sub_addr);
    end

    typedef struct {
        logic [1:0]  req;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        wren;
    } req_t;
    req_t log_q[$];

    always @(negedge clk) begin
        if (o_sub_req != 2'b00) begin
            log_q.push_back('{req: o_sub_req, addr: o_sub_addr, wdata: o_sub_wdata,
                              wren: o_sub_wren});
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  bhw;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_cyc;
        int          exp_nreq;
    } vec_t;

    vec_t vecs[12];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request in cycle 0; returns positioned in cycle 1
    task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] bhw);
        log_q.delete();
        i_write_notread = wr;
        i_bus_address   = addr;
        i_bus_data      = data;
        i_bhw           = bhw;
        i_bus_DV        = 1'b1;
        tick();
        i_bus_DV        = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!o_bus_DV && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int dv_seen;

        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd4, 32'h4433_2211, 1'b0, 9, 4};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 3'd2, 32'hAABB_CCDD, 1'b0, 5, 2};
        vecs[2]  = '{1'b0, 32'h0000_0FFE, 32'h0,         3'd4, 32'hA1A0_4433, 1'b0, 9, 4};
        vecs[3]  = '{1'b0, 32'h0000_2FFE, 32'h0,         3'd4, 32'h0000_4433, 1'b1, 6, 2};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd0, 32'h0,         1'b0, 1, 0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd5, 32'h0,         1'b1, 1, 0};
        vecs[6]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 3'd5, 32'h1234_5678, 1'b1, 1, 0};
        vecs[7]  = '{1'b0, 32'h0000_0013, 32'h0,         3'd1, 32'h0000_0044, 1'b0, 3, 1};
        vecs[8]  = '{1'b1, 32'h0000_0FFE, 32'h0102_0304, 3'd4, 32'h0102_0304, 1'b0, 9, 4};
        vecs[9]  = '{1'b0, 32'h0000_1005, 32'h0,         3'd3, 32'h00A7_A6A5, 1'b0, 7, 3};
        vecs[10] = '{1'b1, 32'h0000_2FFF, 32'hCAFE_BABE, 3'd3, 32'hCAFE_BABE, 1'b1, 4, 1};
        vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         3'd2, 32'h0000_1144, 1'b0, 5, 2};

        i_rst = 1'b1;
        i_bus_DV = 1'b0;
        i_bus_data = '0;
        i_bus_address = '0;
        i_bhw = '0;
        i_write_notread = 1'b0;
        done_en = 1'b1;
        spur = 2'b00;

        tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_dv", 32'(o_bus_DV), 32'd0);
        check("rst_req", 32'(o_sub_req), 32'd0);
        tick();
        i_rst = 1'b0;
        check("post_rst_busy", 32'(o_busy), 32'd0);
        check("post_rst_addr", o_sub_addr, 32'd0);
        check("post_rst_data", o_bus_data, 32'd0);
        check("post_rst_wdata", 32'(o_sub_wdata), 32'd0);

        for (int i = 0; i < 12; i++) begin
            start_req(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].bhw);
            check($sformatf("v%0d_busy", i), 32'(o_busy), 32'd1);
            wait_resp(cyc);
            check($sformatf("v%0d_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_data", i), o_bus_data, vecs[i].exp_data);
            check($sformatf("v%0d_err", i), 32'(o_bus_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_nreq", i), 32'(log_q.size()), 32'(vecs[i].exp_nreq));
            if (i == 1) begin
                check("wr_addr0", log_q[0].addr, 32'h20);
                check("wr_byte0", 32'(log_q[0].wdata), 32'hDD);
                check("wr_addr1", log_q[1].addr, 32'h21);
                check("wr_byte1", 32'(log_q[1].wdata), 32'hCC);
                check("wr_wren", 32'(log_q[1].wren), 32'd1);
            end
            if (i == 2) begin
                check("cross_req0", 32'(log_q[0].req), 32'h1);
                check("cross_req1", 32'(log_q[1].req), 32'h1);
                check("cross_req2", 32'(log_q[2].req), 32'h2);
                check("cross_req3", 32'(log_q[3].req), 32'h2);
            end
            tick();
            check($sformatf("v%0d_idle", i), 32'(o_busy), 32'd0);
        end

        // Done from the other target, or in the request cycle, must be ignored
        done_en = 1'b0;
        start_req(1'b0, 32'h10, 32'h0, 3'd1);
        spur = 2'b11;
        tick();
        spur = 2'b10;
        tick();
        check("spur_no_dv", 32'(o_bus_DV), 32'd0);
        spur = 2'b01;
        tick();
        spur = 2'b00;
        check("spur_dv", 32'(o_bus_DV), 32'd1);
        check("spur_data", o_bus_data, 32'h11);
        tick();

`ifdef MEM_SEQ_TIMEOUT_EN
        start_req(1'b0, 32'h10, 32'h0, 3'd1);
        wait_resp(cyc);
        check("wd_cycle", 32'(cyc), 32'd10);
        check("wd_err", 32'(o_bus_err), 32'd1);
        check("wd_data", o_bus_data, 32'd0);
        tick();
`else
        start_req(1'b0, 32'h10, 32'h0, 3'd1);
        dv_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_bus_DV) dv_seen++;
            tick();
        end
        check("hold_no_dv", 32'(dv_seen), 32'd0);
        check("hold_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
`endif
        done_en = 1'b1;

        // Reset while in WAIT
        start_req(1'b0, 32'h10, 32'h0, 3'd4);
        tick();
        i_rst = 1'b1;
        check("mid_rst_dv", 32'(o_bus_DV), 32'd0);
        tick();
        i_rst = 1'b0;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_req", 32'(o_sub_req), 32'd0);
        log_q.delete();
        dv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (o_bus_DV) dv_seen++;
            tick();
        end
        check("mid_rst_no_dv", 32'(dv_seen), 32'd0);
        check("mid_rst_no_req", 32'(log_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

Parametrised bus-to-submodule memory front end. It accepts one word-sized CPU bus transaction and splits it into sequential byte accesses to one of `NUM_TGT` byte-wide targets (boot RAM, SDRAM controller, peripherals), selected by an external address map. It adds a `o_busy` indication, byte counts sized to the bus width, an error response for unmapped addresses and an optional watchdog. It sits between the CPU bus and the target modules.

## Interface
Parameters:
- `DATA_W`, 32: bus data width; multiple of 8. `LANES = DATA_W/8`.
- `ADDR_W`, 32: bus and target address width.
- `NUM_TGT`, 2: number of byte-wide targets, ≥1.
- `TIMEOUT_CYCLES`, 1024: watchdog limit per byte access. Used only with `MEM_SEQ_TIMEOUT_EN`.

Ports (clock domain `i_clk`; reset is synchronous and active-high):
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_bus_data`  in  DATA_W  write data; lane k is byte k.
- `i_bus_address`  in  ADDR_W  start byte address.
- `i_bus_DV`  in  1  request strobe. Sampled only in IDLE.
- `i_bhw`  in  $clog2(LANES)+1  byte count, 0..LANES.
- `i_write_notread`  in  1  1 = write, 0 = read.
- `o_bus_data`  out  DATA_W  response data.
- `o_bus_DV`  out  1  one-cycle response pulse.
- `o_bus_err`  out  1  error flag. Valid only while `o_bus_DV` is high.
- `o_busy`  out  1  high whenever the block is not in IDLE.
- `o_sub_addr`  out  ADDR_W  current byte address; also drives the external map.
- `o_sub_wdata`  out  8  current write byte.
- `o_sub_wren`  out  1  write qualifier. Equals the latched write bit while `o_sub_req` is nonzero.
- `o_sub_req`  out  NUM_TGT  one-hot request pulse to the selected target.
- `i_sub_sel`  in  NUM_TGT  one-hot target select from the map, combinational on `o_sub_addr`.
- `i_sub_rdata`  in  NUM_TGT*8  read bytes; target t drives slice [8t+7:8t].
- `i_sub_done`  in  NUM_TGT  completion pulse per target.

## Operation
States are IDLE, ISSUE, WAIT and RESP.

- **IDLE:**
  - On `i_bus_DV`, capture data, address, count and direction, clear the lane counter, and go to ISSUE.
  - If the count is 0, go to RESP instead with `o_bus_err`=0.
  - If the count is greater than LANES, go to RESP with `o_bus_err`=1.
- **ISSUE:**
  - Drive `o_sub_addr` = start address + lane and `o_sub_wdata` = captured lane byte.
  - If `i_sub_sel` is zero or not one-hot, go to RESP with err=1 and issue no request.
  - Otherwise assert `o_sub_req` = `i_sub_sel` for this one cycle, latch the target index, and go to WAIT.
- **WAIT:**
  - Only `i_sub_done` of the latched target is honoured. Done pulses from other targets are ignored.
  - On done for a read, store `i_sub_rdata` of the latched target into lane[counter].
  - Increment the lane counter, then go to RESP if lane+1 equals the count, else go to ISSUE.
- **RESP:**
  - `o_bus_DV`=1 for one cycle, then return to IDLE.
  - Read response: collected lanes in little-endian order; lanes at or above the count are 0.
  - Write response: the captured write data, unchanged.
- Address arithmetic wraps modulo 2^ADDR_W. A transfer that crosses a target boundary is legal: the map is re-evaluated for every byte.
- Errors abort the transfer. Bytes already written stay written. Read lanes not yet transferred return 0.
- `i_bus_DV` outside IDLE is ignored; the master must wait until `o_busy` is low.

## Timing
- Every output is 0 during reset and in the cycle after reset.
- Reset mid-transfer forces IDLE. No `o_bus_DV` is produced and no further `o_sub_req` is issued.
- Cycle-level sequence, where cycle 0 samples `i_bus_DV`:
  - Cycle 1 is ISSUE and the first `o_sub_req` is asserted.
  - `i_sub_done` is honoured from the cycle after the request.
  - A `i_sub_done` in the same cycle as `o_sub_req` is ignored.
- With single-cycle targets, an n-byte transfer asserts `o_bus_DV` at cycle 2n+1.
  - n=0 and n>LANES respond at cycle 1.
  - An unmapped first byte responds at cycle 2.
- `o_busy` rises in cycle 1 and falls in the cycle after `o_bus_DV`. A new request can be accepted in that cycle.

## Configuration
- `MEM_SEQ_TIMEOUT_EN` defined:
  - A watchdog counter is cleared in each ISSUE and counts every WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` with no honoured done, go to RESP with err=1.
  - A done arriving after the abort is ignored.
- `MEM_SEQ_TIMEOUT_EN` undefined: no counter is built, and WAIT holds until done.

## Test plan
- **4-byte read:** NUM_TGT=2, address 0x10 maps to target 0, which returns 0x11..0x44 with done one cycle after each request. Require `o_bus_data`=0x44332211, err=0, and `o_bus_DV` at cycle 9.
- **2-byte write:** data 0xAABBCCDD to address 0x20. Require `o_sub_wdata` 0xDD then 0xCC at addresses 0x20 and 0x21, `o_sub_wren`=1, and response data 0xAABBCCDD.
- **Target crossing:** 4-byte read at 0x0FFE where map sel switches from target 0 to target 1 at 0x1000. Require `o_sub_req` sequence 01, 01, 10, 10, and target 1's rdata in lanes 2 and 3.
- **Unmapped byte:** `i_sub_sel`=0 for the third byte. Require err=1, lanes 2 and 3 = 0, and exactly two requests.
- **Timeout and reset:** with the macro defined and TIMEOUT_CYCLES=8, done is never asserted. Require err=1 after 8 WAIT cycles. Separately, asserting `i_rst` during WAIT gives `o_busy`=0 next cycle and no `o_bus_DV`.
- **Count boundaries:** `i_bhw`=0 responds at cycle 1 with no request. `i_bhw`=LANES+1 responds at cycle 1 with err=1.
